// File: rtl/raster_pkg.sv
// raster_pkg: shared vertex/edge/bbox types, setup FSM states and small helpers for triangle setup
package raster_pkg;
  localparam int DATAWIDTH = 12;
  function automatic int area_width(input int dw);
    return 2 * dw + 3;
  endfunction
  localparam int AREA_WIDTH = area_width(DATAWIDTH);
  typedef struct packed {
    logic signed [DATAWIDTH-1:0] x;
    logic signed [DATAWIDTH-1:0] y;
    logic [DATAWIDTH-1:0] z;
  } vertex_t;
  typedef struct packed {
    logic signed [DATAWIDTH:0] a;
    logic signed [DATAWIDTH:0] b;
    logic signed [AREA_WIDTH-1:0] c;
  } edge_coef_t;
  typedef struct packed {
    logic [DATAWIDTH-1:0] min_x;
    logic [DATAWIDTH-1:0] min_y;
    logic [DATAWIDTH-1:0] max_x;
    logic [DATAWIDTH-1:0] max_y;
  } bbox_t;
  typedef enum logic [2:0] {IDLE, EDGE, AREA, CLIP, EMIT} setup_state_t;
  function automatic logic signed [DATAWIDTH-1:0] min3(input logic signed [DATAWIDTH-1:0] a, b, c);
    return (a < b) ? ((a < c) ? a : c) : ((b < c) ? b : c);
  endfunction
  function automatic logic signed [DATAWIDTH-1:0] max3(input logic signed [DATAWIDTH-1:0] a, b, c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
  function automatic logic [DATAWIDTH-1:0] clamp(input logic signed [DATAWIDTH-1:0] v, hi);
    return v[DATAWIDTH-1] ? '0 : ((v > hi) ? hi : v);
  endfunction
endpackage

// File: rtl/edge_setup.sv
// edge_setup: registered edge-function coefficients for the edge v_i -> v_j
// A/B are captured in the EDGE cycle, C one cycle later in the AREA cycle.
module edge_setup
  import raster_pkg::*;
(
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ab_en_i,
  input  logic                        c_en_i,
  input  logic signed [DATAWIDTH-1:0] xi_i,
  input  logic signed [DATAWIDTH-1:0] yi_i,
  input  logic signed [DATAWIDTH-1:0] xj_i,
  input  logic signed [DATAWIDTH-1:0] yj_i,
  output edge_coef_t                  coef_o
);
  logic signed [DATAWIDTH:0] a_d, b_d;
  logic signed [AREA_WIDTH-1:0] c_d;
  edge_coef_t coef_q;
  assign a_d = (DATAWIDTH+1)'(yi_i) - (DATAWIDTH+1)'(yj_i);
  assign b_d = (DATAWIDTH+1)'(xj_i) - (DATAWIDTH+1)'(xi_i);
  assign c_d = AREA_WIDTH'(xi_i) * AREA_WIDTH'(yj_i) - AREA_WIDTH'(xj_i) * AREA_WIDTH'(yi_i);
  always_ff @(posedge clk) begin
    if (!rstn) coef_q <= '0;
    else begin
      if (ab_en_i) begin
        coef_q.a <= a_d;
        coef_q.b <= b_d;
      end
      if (c_en_i) coef_q.c <= c_d;
    end
  end
  assign coef_o = coef_q;
endmodule

// File: rtl/triangle_setup.sv
// triangle_setup: per-triangle edge coefficients, doubled area and clamped bbox with degenerate/off-screen culling.
// Define TRIANGLE_SETUP_BACKFACE_CULL_EN to cull clockwise triangles instead of rewinding them (v1/v2 swap).
module triangle_setup
  import raster_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  vertex_t                      i_v0,
  input  vertex_t                      i_v1,
  input  vertex_t                      i_v2,
  input  logic                         i_dv,
  input  logic                         i_last,
  output logic                         o_ready,
  output vertex_t                      o_v0,
  output vertex_t                      o_v1,
  output vertex_t                      o_v2,
  output logic [2:0][DATAWIDTH:0]      o_edge_a,
  output logic [2:0][DATAWIDTH:0]      o_edge_b,
  output logic [2:0][AREA_WIDTH-1:0]   o_edge_c,
  output logic [AREA_WIDTH-1:0]        o_area,
  output logic [DATAWIDTH-1:0]         o_bb_min_x,
  output logic [DATAWIDTH-1:0]         o_bb_min_y,
  output logic [DATAWIDTH-1:0]         o_bb_max_x,
  output logic [DATAWIDTH-1:0]         o_bb_max_y,
  output logic                         o_dv,
  output logic                         o_last,
  input  logic                         i_ready,
  output logic                         o_done,
  output logic [15:0]                  o_emitted,
  output logic [15:0]                  o_culled
);
  localparam logic signed [DATAWIDTH-1:0] XMAX = DATAWIDTH'(SCREEN_WIDTH - 1);
  localparam logic signed [DATAWIDTH-1:0] YMAX = DATAWIDTH'(SCREEN_HEIGHT - 1);
  setup_state_t state_q;
  vertex_t [2:0] v_q;
  edge_coef_t [2:0] e, eo;
  logic signed [AREA_WIDTH-1:0] area_q, area_d;
  logic signed [DATAWIDTH-1:0] mnx, mxx, mny, mxy;
  logic last_q, clr_q, flip, cull_face, reject;
  // Swapping v1/v2 reverses every edge: new edge k is the negated old edge 2-k.
  for (genvar k = 0; k < 3; k++) begin : g_edge
    edge_setup u_edge (
      .clk     (clk),
      .rstn    (rstn),
      .ab_en_i (state_q == EDGE),
      .c_en_i  (state_q == AREA),
      .xi_i    (v_q[k].x),
      .yi_i    (v_q[k].y),
      .xj_i    (v_q[(k + 1) % 3].x),
      .yj_i    (v_q[(k + 1) % 3].y),
      .coef_o  (e[k])
    );
    assign eo[k] = flip ? '{a: -e[2-k].a, b: -e[2-k].b, c: -e[2-k].c} : e[k];
  end
  assign area_d = AREA_WIDTH'($signed(e[0].b)) * AREA_WIDTH'($signed(e[2].a))
                - AREA_WIDTH'($signed(e[2].b)) * AREA_WIDTH'($signed(e[0].a));
`ifdef TRIANGLE_SETUP_BACKFACE_CULL_EN
  assign flip      = 1'b0;
  assign cull_face = area_q[AREA_WIDTH-1];
`else
  assign flip      = area_q[AREA_WIDTH-1];
  assign cull_face = 1'b0;
`endif
  assign mnx = min3(v_q[0].x, v_q[1].x, v_q[2].x);
  assign mxx = max3(v_q[0].x, v_q[1].x, v_q[2].x);
  assign mny = min3(v_q[0].y, v_q[1].y, v_q[2].y);
  assign mxy = max3(v_q[0].y, v_q[1].y, v_q[2].y);
  assign reject = (area_q == '0) || cull_face || mxx[DATAWIDTH-1] || (mnx > XMAX)
               || mxy[DATAWIDTH-1] || (mny > YMAX);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      v_q <= '0;
      last_q <= 1'b0;
      clr_q <= 1'b0;
      area_q <= '0;
      o_ready <= 1'b1;
      o_v0 <= '0;
      o_v1 <= '0;
      o_v2 <= '0;
      o_edge_a <= '0;
      o_edge_b <= '0;
      o_edge_c <= '0;
      o_area <= '0;
      o_bb_min_x <= '0;
      o_bb_min_y <= '0;
      o_bb_max_x <= '0;
      o_bb_max_y <= '0;
      o_dv <= 1'b0;
      o_last <= 1'b0;
      o_done <= 1'b0;
      o_emitted <= '0;
      o_culled <= '0;
    end else begin
      o_done <= 1'b0;
      case (state_q)
        IDLE: if (i_dv) begin
          v_q <= {i_v2, i_v1, i_v0};
          last_q <= i_last;
          o_ready <= 1'b0;
          state_q <= EDGE;
          if (clr_q) begin
            o_emitted <= '0;
            o_culled <= '0;
            clr_q <= 1'b0;
          end
        end
        EDGE: state_q <= AREA;
        AREA: begin
          area_q <= area_d;
          state_q <= CLIP;
        end
        CLIP: if (reject) begin
          o_culled <= o_culled + 16'(o_culled != 16'hFFFF);
          o_done <= last_q;
          clr_q <= last_q;
          o_ready <= 1'b1;
          state_q <= IDLE;
        end else begin
          o_v0 <= v_q[0];
          o_v1 <= flip ? v_q[2] : v_q[1];
          o_v2 <= flip ? v_q[1] : v_q[2];
          o_edge_a <= {eo[2].a, eo[1].a, eo[0].a};
          o_edge_b <= {eo[2].b, eo[1].b, eo[0].b};
          o_edge_c <= {eo[2].c, eo[1].c, eo[0].c};
          o_area <= flip ? -area_q : area_q;
          o_bb_min_x <= clamp(mnx, XMAX);
          o_bb_min_y <= clamp(mny, YMAX);
          o_bb_max_x <= clamp(mxx, XMAX);
          o_bb_max_y <= clamp(mxy, YMAX);
          o_dv <= 1'b1;
          o_last <= last_q;
          state_q <= EMIT;
        end
        EMIT: if (i_ready) begin
          o_dv <= 1'b0;
          o_last <= 1'b0;
          o_emitted <= o_emitted + 16'(o_emitted != 16'hFFFF);
          o_done <= o_last;
          clr_q <= o_last;
          o_ready <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
